sha256_round_ctrl: RTL and testbench

- Sequences one SHA-256 block compression over the core's enable/reset-controlled 32-bit register bank: the A..H working registers, the H context registers and the W schedule window.
- Decides each cycle which registers load, which source feeds them, and which round index drives the K lookup.
- Takes 16 message words from an upstream word FIFO with stall support, then signals completion to the sha256crypt-level scheduler.

---
 rtl/sha256_round_ctrl.sv | 92 +++++++++
 tb/tb_sha256_round_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_round_ctrl.sv
// SHA-256 round controller: sequences context load, 64 rounds and the H update for one block.
// Rounds below MSG_WORDS consume one upstream word each and stall while none is available.
module sha256_round_ctrl #(
    parameter int unsigned ROUNDS    = 64,
    parameter int unsigned MSG_WORDS = 16,
    parameter int unsigned CNT_W     = 6
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             start,
    input  logic             init_ctx,
    input  logic             in_valid,
    output logic             in_rd,
    output logic             ready,
    output logic             busy,
    output logic             ws_load_en,
    output logic             iv_sel,
    output logic             round_en,
    output logic             w_src,
    output logic [CNT_W-1:0] rnd,
    output logic             h_update_en,
    output logic             done
);

    typedef enum logic [1:0] {StIdle, StLoad, StRound, StAdd} state_e;

    state_e           r_state;
    logic [CNT_W-1:0] r_rnd;
    logic             r_iv_sel;
    logic             r_done;

    logic w_in_round;
    logic w_msg_phase;
    logic w_last;
    logic w_round_en;

    assign w_in_round  = (r_state == StRound);
    assign w_msg_phase = (r_rnd < CNT_W'(MSG_WORDS));
    assign w_last      = (r_rnd == CNT_W'(ROUNDS - 1));
    // Message rounds wait for a word; schedule rounds always advance.
    assign w_round_en  = w_in_round && (!w_msg_phase || in_valid);

    always_ff @(posedge CLK) begin
        if (rst) begin
            r_state  <= StIdle;
            r_rnd    <= '0;
            r_iv_sel <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (start) begin
                        r_state  <= StLoad;
                        r_iv_sel <= init_ctx;
                    end
                end
                StLoad: begin
                    r_state <= StRound;
                    r_rnd   <= '0;
                end
                StRound: begin
                    if (w_round_en) begin
                        if (w_last) begin
                            r_rnd   <= '0;
                            r_state <= StAdd;
                        end else begin
                            r_rnd <= r_rnd + CNT_W'(1);
                        end
                    end
                end
                StAdd: begin
                    r_state <= StIdle;
                    r_done  <= 1'b1;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign ready       = (r_state == StIdle);
    assign busy        = !ready;
    assign ws_load_en  = (r_state == StLoad);
    assign iv_sel      = r_iv_sel;
    assign round_en    = w_round_en;
    assign w_src       = w_in_round && w_msg_phase;
    assign in_rd       = w_in_round && w_msg_phase && in_valid;
    assign rnd         = r_rnd;
    assign h_update_en = (r_state == StAdd);
    assign done        = r_done;

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Directed bench for sha256_round_ctrl: expected round records are queued when a block is
// launched and popped on every observed round_en.
module tb_sha256_round_ctrl;

    localparam int ROUNDS = 64;
    localparam int MSG    = 16;

    logic       CLK = 1'b0;
    logic       rst, start, init_ctx, in_valid;
    logic       in_rd, ready, busy, ws_load_en, iv_sel, round_en, w_src, h_update_en, done;
    logic [5:0] rnd;

    typedef struct packed {
        logic [5:0] rnd;
        logic       in_rd;
        logic       w_src;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   stall_left[64];
    int   d1, d2;

    always #5 CLK = ~CLK;

    sha256_round_ctrl #(
        .ROUNDS   (64),
        .MSG_WORDS(16),
        .CNT_W    (6)
    ) dut (
        .CLK        (CLK),
        .rst        (rst),
        .start      (start),
        .init_ctx   (init_ctx),
        .in_valid   (in_valid),
        .in_rd      (in_rd),
        .ready      (ready),
        .busy       (busy),
        .ws_load_en (ws_load_en),
        .iv_sel     (iv_sel),
        .round_en   (round_en),
        .w_src      (w_src),
        .rnd        (rnd),
        .h_update_en(h_update_en),
        .done       (done)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Launches one block (start asserted before the next edge) and follows it to done.
    task automatic run_block(input logic init, input bit hold_start, input bit busy_pulse,
                             input int exp_lat, output int done_cyc);
        int         lat, done_lat, h_lat, h_cnt, rd_cnt;
        bit         pulsed;
        exp_t       rec;
        logic [5:0] r;
        logic       exp_re;
        start    = 1'b1;
        init_ctx = init;
        in_valid = 1'b1;
        tick();
        lat   = 1;
        start = hold_start;
        #1;
        chk("load_ws_load_en", ws_load_en, 1);
        chk("load_iv_sel", iv_sel, init);
        chk("load_rnd", rnd, 0);
        chk("load_busy", busy, 1);
        chk("load_in_rd", in_rd, 0);
        for (int i = 0; i < ROUNDS; i++)
            sb.push_back(exp_t'{rnd: 6'(i), in_rd: (i < MSG), w_src: (i < MSG)});
        rd_cnt = 0;
        pulsed = 1'b0;
        while (sb.size() > 0 && lat < 400) begin
            tick();
            lat++;
            r     = sb[0].rnd;
            start = hold_start;
            if (busy_pulse && !pulsed && r == 6'd10) begin
                start  = 1'b1;
                pulsed = 1'b1;
            end
            if (stall_left[r] > 0) begin
                in_valid = 1'b0;
                stall_left[r]--;
            end else begin
                in_valid = 1'b1;
            end
            exp_re = in_valid || (r >= 6'(MSG));
            #1;
            chk("round_en", round_en, exp_re);
            chk("rnd", rnd, r);
            chk("ws_load_en_in_round", ws_load_en, 0);
            chk("h_update_in_round", h_update_en, 0);
            if (in_rd) rd_cnt++;
            if (round_en) begin
                rec = sb.pop_front();
                chk("in_rd", in_rd, rec.in_rd);
                chk("w_src", w_src, rec.w_src);
            end else begin
                chk("in_rd_stall", in_rd, 0);
            end
        end
        chk("rounds_left_at_timeout", sb.size(), 0);
        sb.delete();
        chk("in_rd_count", rd_cnt, MSG);
        in_valid = 1'b1;
        done_lat = -1;
        h_lat    = -1;
        h_cnt    = 0;
        for (int k = 0; k < 6 && done_lat < 0; k++) begin
            tick();
            lat++;
            start = hold_start;
            #1;
            if (h_update_en) begin
                h_cnt++;
                h_lat = lat;
            end
            if (done) begin
                done_lat = lat;
                chk("done_ready", ready, 1);
                chk("done_no_h_update", h_update_en, 0);
            end
        end
        chk("h_update_latency", h_lat, exp_lat - 1);
        chk("h_update_count", h_cnt, 1);
        chk("done_latency", done_lat, exp_lat);
        done_cyc = cyc;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        start    = 1'b1;
        init_ctx = 1'b1;
        in_valid = 1'b1;
        foreach (stall_left[i]) stall_left[i] = 0;

        // Reset dominates a held start.
        for (int k = 0; k < 3; k++) begin
            tick();
            #1;
            chk("rst_ready", ready, 1);
            chk("rst_busy", busy, 0);
            chk("rst_ws_load_en", ws_load_en, 0);
            chk("rst_round_en", round_en, 0);
            chk("rst_h_update_en", h_update_en, 0);
            chk("rst_in_rd", in_rd, 0);
            chk("rst_done", done, 0);
            chk("rst_rnd", rnd, 0);
            chk("rst_iv_sel", iv_sel, 0);
        end
        rst = 1'b0;
        tick();
        #1;
        chk("rst_release_load", ws_load_en, 1);
        chk("rst_release_iv_sel", iv_sel, 1);
        rst = 1'b1;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        #1;
        chk("reabort_ready", ready, 1);

        // Plain block from IV.
        run_block(1'b1, 1'b0, 1'b0, 67, d1);
        tick();

        // Stalls during message rounds; a low in_valid at rnd 20 must not stall.
        stall_left[3]  = 5;
        stall_left[15] = 2;
        stall_left[20] = 3;
        run_block(1'b0, 1'b0, 1'b0, 74, d1);
        foreach (stall_left[i]) stall_left[i] = 0;
        tick();

        // Back-to-back with start held high.
        run_block(1'b1, 1'b1, 1'b0, 67, d1);
        run_block(1'b0, 1'b0, 1'b0, 67, d2);
        chk("b2b_done_gap", d2 - d1, 67);
        tick();
        #1;
        chk("b2b_no_third_block", ready, 1);

        // start pulsed mid-block is dropped.
        run_block(1'b1, 1'b0, 1'b1, 67, d1);
        for (int k = 0; k < 4; k++) begin
            tick();
            #1;
            chk("busy_start_no_done", done, 0);
            chk("busy_start_no_load", ws_load_en, 0);
            chk("busy_start_ready", ready, 1);
        end

        // Abort at rnd 40.
        start    = 1'b1;
        init_ctx = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 100; k++) begin
            tick();
            #1;
            if (rnd == 6'd40) break;
        end
        chk("abort_reach_rnd40", rnd, 40);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("abort_ready", ready, 1);
        chk("abort_rnd", rnd, 0);
        chk("abort_done", done, 0);
        chk("abort_h_update", h_update_en, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            #1;
            chk("abort_idle_done", done, 0);
            chk("abort_idle_h_update", h_update_en, 0);
        end
        run_block(1'b0, 1'b0, 1'b0, 67, d1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
